// File: rtl/secuenciador_pkg.sv
// Shared definitions for the secuenciador sequence source: mode encoding and legal WIDTH range.
package secuenciador_pkg;

    typedef enum logic [1:0] {
        MODE_UP      = 2'd0,
        MODE_DOWN    = 2'd1,
        MODE_GRAY    = 2'd2,
        MODE_JOHNSON = 2'd3
    } mode_e;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 16;

endpackage

// File: rtl/secuenciador_enc.sv
// Output encoder: maps the state register and registered mode onto F (F[0] is the MSB).
module secuenciador_enc
    import secuenciador_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] state_i,
    input  mode_e            mode_i,
    output logic [0:WIDTH-1] f_o
);

    // Assigning a descending vector to the ascending port keeps state MSB on f_o[0].
    always_comb begin
        if (mode_i == MODE_GRAY) begin
            f_o = state_i ^ (state_i >> 1);
        end else begin
            f_o = state_i;
        end
    end

endmodule

// File: rtl/secuenciador_param.sv
// Parametrised sequence source (up, down, Gray, Johnson) with enable, synchronous load and wrap pulse.
// Build option: define SECUENCIADOR_WRAP_EN to generate wrap; otherwise wrap is tied low.
module secuenciador_param
    import secuenciador_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [0:WIDTH-1] F,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ONE          = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] JOHNSON_LAST = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] state_q, state_d;
    mode_e            mode_q, mode_d, mode_in;
    logic             mode_chg;

    assign mode_in  = mode_e'(mode);
    assign mode_chg = (mode_in != mode_q);

    // Priority: mode change, then load, then step; a mode change discards a coincident load.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        if (mode_chg) begin
            mode_d  = mode_in;
            state_d = '0;
        end else if (load) begin
            state_d = load_val;
        end else if (en) begin
            unique case (mode_q)
                MODE_DOWN:    state_d = state_q - ONE;
                MODE_JOHNSON: state_d = {state_q[WIDTH-2:0], ~state_q[WIDTH-1]};
                default:      state_d = state_q + ONE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
            mode_q  <= MODE_UP;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
        end
    end

`ifdef SECUENCIADOR_WRAP_EN
    logic wrap_q, wrap_d;

    always_comb begin
        wrap_d = 1'b0;
        if (!mode_chg && !load && en) begin
            unique case (mode_q)
                MODE_DOWN:    wrap_d = (state_q == '0);
                MODE_JOHNSON: wrap_d = (state_q == JOHNSON_LAST);
                default:      wrap_d = &state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign wrap = wrap_q;
`else
    assign wrap = 1'b0;
`endif

    secuenciador_enc #(
        .WIDTH (WIDTH)
    ) u_enc (
        .state_i (state_q),
        .mode_i  (mode_q),
        .f_o     (F)
    );

endmodule

// File: tb/tb_secuenciador_param.sv
// Self-checking bench for secuenciador_param (WIDTH = 4): directed scenarios plus randomized traffic
// compared against an arithmetic reference model.
module tb_secuenciador_param;

    localparam int W    = 4;
    localparam int MOD  = 1 << W;
    localparam int MASK = MOD - 1;
`ifdef SECUENCIADOR_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic [1:0]   mode = 2'd0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [0:W-1] F;
    logic         wrap;

    bit clk_run = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    int m_state = 0;
    int m_mode  = 0;
    bit m_wrap  = 1'b0;

    secuenciador_param #(
        .WIDTH (W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
        .F        (F),
        .wrap     (wrap)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int exp_f();
        return (m_mode == 2) ? (m_state ^ (m_state >> 1)) : m_state;
    endfunction

    function automatic void model_reset();
        m_state = 0;
        m_mode  = 0;
        m_wrap  = 1'b0;
    endfunction

    // Reference behaviour: sequences expressed as modular arithmetic on an integer.
    function automatic void model_edge(input bit e, input int md, input bit ld, input int lv);
        int nxt;
        if (md != m_mode) begin
            m_mode  = md;
            m_state = 0;
            m_wrap  = 1'b0;
        end else if (ld) begin
            m_state = lv & MASK;
            m_wrap  = 1'b0;
        end else if (e) begin
            case (m_mode)
                1:       nxt = (m_state + MOD - 1) % MOD;
                3:       nxt = ((m_state * 2) & MASK) + (1 - (m_state / (MOD / 2)));
                default: nxt = (m_state + 1) % MOD;
            endcase
            case (m_mode)
                1:       m_wrap = (m_state == 0);
                3:       m_wrap = (m_state == MOD / 2) && (nxt == 0);
                default: m_wrap = (m_state == MASK) && (nxt == 0);
            endcase
            m_state = nxt;
        end else begin
            m_wrap = 1'b0;
        end
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_F"}, 16'(F), 16'(exp_f()));
        check({tag, "_wrap"}, 16'(wrap), 16'(WRAP_EN ? m_wrap : 1'b0));
    endtask

    task automatic cycle(input bit e, input int md, input bit ld, input int lv, input string tag);
        en       = e;
        mode     = 2'(md);
        load     = ld;
        load_val = W'(lv);
        @(posedge clk);
        model_edge(e, md, ld, lv);
        #1;
        check_outputs(tag);
    endtask

    // Asserts reset with the clock parked high, checks outputs clear immediately, then restarts.
    task automatic async_reset(input string tag);
        clk_run = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs(tag);
        #2;
        rst_n = 1'b1;
        #2;
        clk_run = 1'b1;
    endtask

    initial begin
        #3;
        model_reset();
        check_outputs("reset_init");
        #4;
        rst_n = 1'b1;
        #2;
        clk_run = 1'b1;

        for (int i = 0; i < 17; i++) cycle(1'b1, 0, 1'b0, 0, "up");

        for (int i = 0; i < 4; i++) cycle(1'b1, 0, 1'b0, 0, "up_pre_rst");
        check("up_at_5", 16'(F), 16'd5);
        async_reset("reset_mid");
        cycle(1'b1, 0, 1'b0, 0, "up_after_rst");
        check("first_after_rst", 16'(F), 16'd1);

        for (int i = 0; i < 15; i++) cycle(1'b1, 0, 1'b0, 0, "up_to_wrap");
        async_reset("reset_on_wrap");

        cycle(1'b1, 2, 1'b0, 0, "gray_chg");
        for (int i = 0; i < 17; i++) cycle(1'b1, 2, 1'b0, 0, "gray");
        cycle(1'b0, 2, 1'b0, 0, "gray_hold");

        cycle(1'b1, 3, 1'b0, 0, "john_chg");
        for (int i = 0; i < 16; i++) cycle(1'b1, 3, 1'b0, 0, "john");
        cycle(1'b1, 3, 1'b1, 5, "john_load_odd");
        for (int i = 0; i < 10; i++) cycle(1'b1, 3, 1'b0, 0, "john_odd");

        cycle(1'b1, 1, 1'b0, 0, "down_chg");
        cycle(1'b1, 1, 1'b1, 'hA, "load_vs_en");
        check("load_wins", 16'(F), 16'hA);
        cycle(1'b1, 1, 1'b0, 0, "down_9");
        cycle(1'b1, 1, 1'b0, 0, "down_8");
        cycle(1'b1, 0, 1'b1, 'h7, "chg_vs_load");
        check("chg_wins", 16'(F), 16'h0);

        for (int i = 0; i < 5; i++) cycle(1'b1, 0, 1'b0, 0, "up_to_5");
        cycle(1'b1, 1, 1'b0, 0, "up_to_down");
        cycle(1'b1, 1, 1'b0, 0, "down_wrap");
        check("down_wrap_F", 16'(F), 16'd15);
        cycle(1'b1, 1, 1'b0, 0, "down_14");

        for (int i = 0; i < 400; i++) begin
            int  md;
            bit  e;
            bit  ld;
            md = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : m_mode;
            e  = ($urandom_range(0, 4) != 0);
            ld = ($urandom_range(0, 7) == 0);
            cycle(e, md, ld, int'($urandom_range(0, MASK)), "rand");
            if ($urandom_range(0, 99) == 0) async_reset("rand_reset");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/secuenciador_param.md
# secuenciador_param

Parametrised successive-state generator: a clocked sequence source that steps a WIDTH-bit output through one of four selectable sequences (binary up, binary down, Gray, Johnson). Supports an enable, a synchronous load and a wrap indication. It generalises the fixed 4-bit successive-process generator and drives downstream display and stimulus logic in the entity-integration design.

## Interface
- WIDTH, 4, output width in bits; legal range 2..16
- clk  in  1  system clock, rising-edge active
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  step enable; advance one sequence step per clock when high
- mode  in  2  sequence select: 0 = up, 1 = down, 2 = Gray, 3 = Johnson
- load  in  1  synchronous load strobe
- load_val  in  WIDTH  value loaded into the state register
- F  out  [0:WIDTH-1]  sequence output; F[0] is the MSB
- wrap  out  1  one-cycle pulse marking sequence wrap-around

## Operation
- Internal registers:
  - state[WIDTH-1:0]
  - mode_q[1:0], the registered mode
  - wrap (registered)
- F is a pure function of state and mode_q:
  - up, down, Johnson: F = state
  - Gray: F = state ^ (state >> 1)
- Per-edge priority, highest first: reset, mode change, load, en step, hold.
  - Mode change (mode != mode_q): mode_q <= mode, state <= 0, wrap <= 0.
  - Load: state <= load_val, wrap <= 0. No encoding is applied; Gray mode shows the Gray code of load_val.
  - Step, up or Gray: state <= state + 1, modulo 2^WIDTH.
  - Step, down: state <= state - 1, modulo 2^WIDTH.
  - Step, Johnson: state <= {state[WIDTH-2:0], ~state[WIDTH-1]}. Period is 2·WIDTH from any valid Johnson code.
  - Hold (en = 0): state unchanged, wrap <= 0.
- wrap is set for exactly one cycle after a step that crosses the sequence boundary:
  - up/Gray: all-ones -> 0
  - down: 0 -> all-ones
  - Johnson: {1, 0…0} -> 0
- wrap is never set by load, mode change or reset.
- Loading a non-Johnson pattern in Johnson mode is legal. The register then shifts per the rule and wrap fires only on the defined transition.

## Timing
- Reset (async assert, sync-safe release): state = 0, mode_q = 0, F = 0, wrap = 0 immediately, no clock required.
- The first edge after release, with mode != 0, is treated as a mode change.
- Latency is one cycle for every action: an input sampled at edge k is visible on F/wrap after edge k.
- F changes only after clock edges or asynchronous reset; no combinational path from any input to F or wrap.
- Simultaneous events:
  - load + en: load wins.
  - mode change + load: mode change wins and the load is discarded.
- Reset mid-sequence aborts immediately; counting resumes from 0.

## Configuration
- SECUENCIADOR_WRAP_EN
  - Defined: wrap is generated as described above.
  - Undefined: wrap is tied to 0 and its register and detection logic are removed. The port is retained for pin compatibility.
- Sequencing is identical in both builds.

## Structure
- secuenciador_pkg:
  - mode constants MODE_UP, MODE_DOWN, MODE_GRAY, MODE_JOHNSON
  - mode type (2-bit)
  - WIDTH limits
- Sub-module secuenciador_enc: combinational mapping of (state, mode_q) to F. The top level holds all registers and next-state logic.

## Test plan
All scenarios use WIDTH = 4.
- Reset: rst_n = 0 mid-count with clk stopped -> F = 0 and wrap = 0 at once; after release, with en = 1 in up mode, F = 1 after the first edge.
- Up: en = 1 for 17 edges -> F = 0,1,…,15,0,1; wrap = 1 for exactly the cycle where F returns to 0.
- Gray: mode = 2, en = 1 -> F = 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100…; wrap after 16 steps, when F returns to 0000.
- Johnson: mode = 3, en = 1 -> F = 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000; wrap = 1 only on the return to 0000 (8-step period).
- Load/priority: down mode, load = 1 and en = 1 with load_val = 4'hA -> F = A (not 9); then en only -> 9, 8. Mode change and load on the same edge -> F = 0.
- Mode change: up at F = 5, mode -> down -> F = 0 with no wrap; next step F = 15 with wrap = 1. With SECUENCIADOR_WRAP_EN undefined, wrap stays 0 throughout.
